// File: rtl/l2_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types (L2 port arbiter slice)
// Shared types for the L2 line-port arbiter.
//   lc3b_word   : 16-bit address word
//   lc3b_c_line : 128-bit cache line
//   arb_state_t : arbiter FSM states (IDLE, SERVE_I, SERVE_D, RELEASE)
//   arb_req_t   : requester identity (REQ_I, REQ_D)
// -----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/l2_port_arbiter_mux.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter_mux
// Combinational downstream mux: drives the memory request fields from the
// granted requester, or all-zero when nothing is granted.
// Ports:
//   grant_en, grant_sel             : grant valid and granted requester
//   i_strobe, i_addr                : I-side request (always a read)
//   d_strobe, d_write, d_addr, d_wdata : D-side request
//   mem_strobe, mem_write, mem_addr, mem_wdata : downstream request
// -----------------------------------------------------------------------------
module l2_port_arbiter_mux
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              grant_en,
  input  arb_req_t          grant_sel,
  input  logic              i_strobe,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_strobe,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              mem_strobe,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata
);

  always_comb begin
    mem_strobe = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (grant_en) begin
      if (grant_sel == REQ_D) begin
        mem_strobe = d_strobe;
        mem_write  = d_write;
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
      end else begin
        // The I-side only ever reads; write data stays zero.
        mem_strobe = i_strobe;
        mem_addr   = i_addr;
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter
// Shares the single L2 line port between the I-cache miss path and the D-side
// (D-cache behind its eviction buffer). One transaction at a time; the grant
// is locked until mem_resp, followed by a one-cycle RELEASE gap so a stale
// requester strobe in the cycle after resp is never re-arbitrated.
//
// Handshake (all three ports): strobe is held by the requester until resp;
// resp is a one-cycle completion pulse; read data is valid only with resp.
//
// Optional feature: define L2_ARB_ROUND_ROBIN_EN to replace fixed D-over-I
// priority with round-robin on simultaneous requests (rr_last register).
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_strobe, i_addr, i_rdata, i_resp : I-side request/response
//   d_strobe, d_write, d_addr, d_wdata, d_rdata, d_resp : D-side
//   mem_strobe, mem_write, mem_addr, mem_wdata, mem_rdata, mem_resp : L2
//   state                           : current FSM state (debug)
// -----------------------------------------------------------------------------
module l2_port_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_strobe,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_strobe,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_strobe,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output arb_state_t        state
);

  arb_state_t state_q, state_d;
  logic       pick_d;
  logic       grant_en;
  arb_req_t   grant_sel;

`ifdef L2_ARB_ROUND_ROBIN_EN
  // Last requester granted; simultaneous requests go to the other one.
  arb_req_t rr_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= REQ_I;
    end else if (state_q == IDLE && state_d == SERVE_D) begin
      rr_last <= REQ_D;
    end else if (state_q == IDLE && state_d == SERVE_I) begin
      rr_last <= REQ_I;
    end
  end

  assign pick_d = d_strobe && (!i_strobe || (rr_last == REQ_I));
`else
  // Fixed D-over-I priority; the eviction buffer bounds D traffic.
  assign pick_d = d_strobe;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
        end else if (i_strobe) begin
          state_d = SERVE_I;
        end
      end
      // Grant stays locked until mem_resp even if the strobe drops early.
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant_en  = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign grant_sel = (state_q == SERVE_D) ? REQ_D : REQ_I;

  // mem_resp outside a SERVE state is ignored.
  assign i_resp  = (state_q == SERVE_I) && mem_resp;
  assign d_resp  = (state_q == SERVE_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign state   = state_q;

  l2_port_arbiter_mux #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_mux (
    .grant_en  (grant_en),
    .grant_sel (grant_sel),
    .i_strobe  (i_strobe),
    .i_addr    (i_addr),
    .d_strobe  (d_strobe),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .mem_strobe(mem_strobe),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_port_arbiter
// Directed bench for l2_port_arbiter. Stimulus pushes expected downstream
// requests into mem_q and expected responses into exp_q; a negedge monitor
// pops and compares on each mem_strobe rise and each i_resp/d_resp pulse.
// A small memory responder answers each downstream request after lat cycles.
// -----------------------------------------------------------------------------
module tb_l2_port_arbiter;
  import lc3b_types::*;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int MW     = 1 + ADDR_W + LINE_W;
  localparam int RW     = 1 + LINE_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_strobe;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_strobe;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_strobe;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  arb_state_t        state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 4;
  bit stray  = 1'b0;

  logic [MW-1:0] mem_q[$];
  logic [RW-1:0] exp_q[$];

  l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_strobe(i_strobe), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_strobe(d_strobe), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_strobe(mem_strobe), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .state(state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    if (a == 16'h1230) return {16{8'hA5}};
    return {8{a}};
  endfunction

  task automatic chk(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic              busy = 1'b0;
  int                cnt  = 0;
  logic [ADDR_W-1:0] cap_addr = '0;

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      busy = 1'b0; cnt = 0; mem_resp = 1'b0;
    end else if (mem_resp) begin
      mem_resp = 1'b0; mem_rdata = '0;
    end else if (busy) begin
      if (cnt == 0) begin
        mem_resp = 1'b1; mem_rdata = line_of(cap_addr); busy = 1'b0;
      end else begin
        cnt--;
      end
    end else if (stray) begin
      mem_resp = 1'b1; mem_rdata = {8{16'hBEEF}}; stray = 1'b0;
    end else if (mem_strobe) begin
      busy = 1'b1; cnt = lat - 1; cap_addr = mem_addr;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic prev_mem_strobe = 1'b0;

  always @(negedge clk) begin
    logic [MW-1:0] me;
    logic [RW-1:0] re;
    if (!rst_n) begin
      prev_mem_strobe = 1'b0;
    end else begin
      if (mem_strobe && !prev_mem_strobe) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_req unexpected got=%h", {mem_write, mem_addr, mem_wdata});
        end else begin
          me = mem_q.pop_front();
          if ({mem_write, mem_addr, mem_wdata} !== me) begin
            errors++;
            $display("FAIL mem_req got=%h exp=%h", {mem_write, mem_addr, mem_wdata}, me);
          end
        end
      end
      if (i_resp || d_resp) begin
        checks++;
        if (i_resp && d_resp) begin
          errors++;
          $display("FAIL resp both i_resp and d_resp high");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp unexpected side=%0d", d_resp);
        end else begin
          re = exp_q.pop_front();
          if ({d_resp, (d_resp ? d_rdata : i_rdata)} !== re) begin
            errors++;
            $display("FAIL resp got=%h exp=%h", {d_resp, (d_resp ? d_rdata : i_rdata)}, re);
          end
        end
      end
      prev_mem_strobe = mem_strobe;
    end
  end

  // ---------------- driver tasks ----------------
  // hold < 0: leave strobe asserted on return (caller chains another request).
  task automatic i_txn(input logic [ADDR_W-1:0] addr, input int hold,
                       output int t_req, output int t_grant, output int t_resp);
    int n;
    t_grant = -1; t_resp = -1;
    @(posedge clk); #1;
    i_strobe = 1'b1; i_addr = addr; t_req = cyc;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (t_grant < 0 && mem_strobe && !mem_write && mem_addr == addr) t_grant = cyc;
    end while (!i_resp && n < 100);
    if (!i_resp) begin
      checks++; errors++;
      $display("FAIL i_timeout addr=%h got=no_resp exp=resp", addr);
    end else begin
      t_resp = cyc;
    end
    if (hold >= 0) begin
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      i_strobe = 1'b0;
    end
  endtask

  task automatic d_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] wdata, input int hold,
                       output int t_req, output int t_grant, output int t_resp);
    int n;
    t_grant = -1; t_resp = -1;
    @(posedge clk); #1;
    d_strobe = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata; t_req = cyc;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (t_grant < 0 && mem_strobe && mem_addr == addr) t_grant = cyc;
    end while (!d_resp && n < 100);
    if (!d_resp) begin
      checks++; errors++;
      $display("FAIL d_timeout addr=%h got=no_resp exp=resp", addr);
    end else begin
      t_resp = cyc;
    end
    if (hold >= 0) begin
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      d_strobe = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tq, tg, tr, tq2, tg2, tr2;
    bit quiet;
    rst_n = 1'b0; i_strobe = 1'b0; i_addr = '0;
    d_strobe = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = {4{32'hDEADC0DE}};

    // Reset state: outputs deasserted, read data passes through.
    @(negedge clk);
    chk("rst_state", MW'(state), MW'(IDLE));
    chk("rst_mem", {mem_strobe, mem_write, mem_addr, mem_wdata}, '0);
    chk("rst_resp", MW'({i_resp, d_resp}), '0);
    chk("rst_rdata", MW'({i_rdata, d_rdata}), MW'({8{32'hDEADC0DE}}));
    @(posedge clk); #1; rst_n = 1'b1;

    // Single I read, 4-cycle memory latency.
    mem_q.push_back({1'b0, 16'h1230, 128'h0});
    exp_q.push_back({1'b0, {16{8'hA5}}});
    i_txn(16'h1230, 0, tq, tg, tr);
    chk("i_arb_latency", MW'(tg - tq), MW'(1));
    chk("i_mem_latency", MW'(tr - tg), MW'(4));

    // D writeback, then RELEASE gap.
    mem_q.push_back({1'b1, 16'h4000, {8{16'h1111}}});
    exp_q.push_back({1'b1, {8{16'h4000}}});
    d_txn(1'b1, 16'h4000, {8{16'h1111}}, 0, tq, tg, tr);
    chk("d_arb_latency", MW'(tg - tq), MW'(1));
    @(negedge clk);
    chk("release_state", MW'({mem_strobe, state}), MW'({1'b0, RELEASE}));
    @(negedge clk);
    chk("after_release", MW'(state), MW'(IDLE));

    // Stray mem_resp in IDLE is not forwarded.
    @(posedge clk); #1; stray = 1'b1;
    @(negedge clk);
    chk("stray_resp", MW'({mem_resp, i_resp, d_resp, state}), MW'({3'b100, IDLE}));
    @(negedge clk);
    chk("stray_state", MW'(state), MW'(IDLE));

    // Simultaneous requests from reset: D first, I granted after RELEASE+IDLE.
    pulse_reset();
    mem_q.push_back({1'b1, 16'h4400, {8{16'h2222}}});
    mem_q.push_back({1'b0, 16'h2222, 128'h0});
    exp_q.push_back({1'b1, {8{16'h4400}}});
    exp_q.push_back({1'b0, {8{16'h2222}}});
    fork
      d_txn(1'b1, 16'h4400, {8{16'h2222}}, 0, tq, tg, tr);
      i_txn(16'h2222, 0, tq2, tg2, tr2);
    join
    chk("sim_d_first", MW'(tg), MW'(tq + 1));
    chk("sim_i_after_dresp", MW'(tg2 - tr), MW'(3));

    // Three grants with D re-requesting straight after its first resp.
    pulse_reset();
`ifdef L2_ARB_ROUND_ROBIN_EN
    mem_q.push_back({1'b0, 16'h7000, 128'h0});
    mem_q.push_back({1'b0, 16'h2500, 128'h0});
    mem_q.push_back({1'b0, 16'h7100, 128'h0});
    exp_q.push_back({1'b1, {8{16'h7000}}});
    exp_q.push_back({1'b0, {8{16'h2500}}});
    exp_q.push_back({1'b1, {8{16'h7100}}});
`else
    mem_q.push_back({1'b0, 16'h7000, 128'h0});
    mem_q.push_back({1'b0, 16'h7100, 128'h0});
    mem_q.push_back({1'b0, 16'h2500, 128'h0});
    exp_q.push_back({1'b1, {8{16'h7000}}});
    exp_q.push_back({1'b1, {8{16'h7100}}});
    exp_q.push_back({1'b0, {8{16'h2500}}});
`endif
    fork
      begin
        d_txn(1'b0, 16'h7000, '0, -1, tq, tg, tr);
        d_txn(1'b0, 16'h7100, '0, 0, tq, tg, tr);
      end
      i_txn(16'h2500, 0, tq2, tg2, tr2);
    join

    // Stale strobe for one cycle after resp: no second request.
    mem_q.push_back({1'b0, 16'h3000, 128'h0});
    exp_q.push_back({1'b0, {8{16'h3000}}});
    i_txn(16'h3000, 1, tq, tg, tr);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_strobe) quiet = 1'b0;
    end
    chk("stale_no_reissue", MW'(quiet), MW'(1'b1));

    // Strobe held through RELEASE and IDLE: a new transaction starts.
    mem_q.push_back({1'b0, 16'h3100, 128'h0});
    mem_q.push_back({1'b0, 16'h3100, 128'h0});
    exp_q.push_back({1'b0, {8{16'h3100}}});
    exp_q.push_back({1'b0, {8{16'h3100}}});
    i_txn(16'h3100, -1, tq, tg, tr);
    i_txn(16'h3100, 0, tq, tg, tr);
    chk("held_regrant", MW'(tg - tq), MW'(2));

    // Reset in the middle of SERVE_D.
    lat = 8;
    mem_q.push_back({1'b0, 16'h5000, 128'h0});
    @(posedge clk); #1;
    d_strobe = 1'b1; d_write = 1'b0; d_addr = 16'h5000; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("mid_serve_d", MW'({mem_strobe, state}), MW'({1'b1, SERVE_D}));
    #2; rst_n = 1'b0;
    #1;
    chk("mid_rst_out", MW'({mem_strobe, d_resp, state}), MW'({2'b00, IDLE}));
    d_strobe = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (mem_strobe || i_resp || d_resp) quiet = 1'b0;
    end
    chk("post_rst_quiet", MW'(quiet), MW'(1'b1));
    lat = 2;
    mem_q.push_back({1'b0, 16'h6000, 128'h0});
    exp_q.push_back({1'b0, {8{16'h6000}}});
    i_txn(16'h6000, 0, tq, tg, tr);
    chk("recover_latency", MW'(tr - tg), MW'(2));

    repeat (4) @(negedge clk);
    chk("drain_mem_q", MW'(mem_q.size()), '0);
    chk("drain_exp_q", MW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
